fft_frame_buffer: RTL and testbench
===================================

# fft_frame_buffer

Parametrised, registered inter-stage frame buffer for the FFT datapath. It accepts one complex sample per cycle over a valid/ready stream and assembles N-point frames into a two-bank ping-pong store. It presents each completed frame as a parallel N-sample output bus under a valid/ready handshake. It sits between the serial input front-end (or a serial stage) and the parallel butterfly stage 1, replacing the pass-through combinational buffer with real framing, back-pressure and double buffering.

## Interface
- WIDTH, 16, bit width of each real/imag sample (signed two's complement)
- N, 16, frame length in complex samples; power of two, 4..64
- LOG2N, $clog2(N), derived; not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample this cycle
- xr_in / xi_in  in  WIDTH each  signed real/imag input sample
- in_last  in  1  marks final sample of a frame (qualified by in_valid)
- out_valid  out  1  a complete frame is presented
- out_ready  in  1  downstream accepts the frame
- yr_out / yi_out  out  N*WIDTH each  frame; sample k at bits [k*WIDTH +: WIDTH]
- frame_err  out  1  one-cycle pulse on framing error

## Operation
- Input handshake: sample accepted when in_valid && in_ready. Output handshake: frame released when out_valid && out_ready.
- Two banks, each with state EMPTY, FILLING or FULL. wr_bank points to the bank being filled; rd_bank points to the bank presented.
- Accepted sample k (k = sample counter 0..N-1) is written to slot k of wr_bank. EMPTY goes to FILLING on the first accept.
- The accept at k = N-1 moves the bank to FULL, toggles wr_bank and resets k to 0.
- in_last on an accept with k != N-1: pulse frame_err. Discard the partial frame: bank goes to EMPTY, k goes to 0, wr_bank is unchanged.
- Accept at k = N-1 without in_last: the frame still completes normally and frame_err pulses.
- in_ready = (bank[wr_bank] != FULL) && rst_n. The value is combinational from registered state.
- out_valid = (bank[rd_bank] == FULL). yr_out/yi_out are driven from the rd_bank storage and are stable while out_valid && !out_ready.
- Output handshake sets bank[rd_bank] to EMPTY and toggles rd_bank.
- Both banks FULL: in_ready = 0. in_ready rises the cycle after the output handshake that frees a bank.
- Simultaneous input accept and output release on different banks are both honoured in the same cycle.
- No arithmetic is performed; samples are stored bit-exact.

## Timing
- Reset (rst_n low at a clk edge) clears the following:
  - both banks go to EMPTY and all storage to 0
  - wr_bank = rd_bank = 0, k = 0
  - out_valid = 0, frame_err = 0, yr_out/yi_out = 0
- in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-frame or mid-presentation drops all data with no error pulse.
- Latency: the final sample accepted at edge t gives out_valid = 1 in the cycle after t, with all N samples valid.
- Sustained throughput: one sample per cycle with no bubbles, provided downstream releases each frame within N cycles.
- frame_err is registered and asserts in the cycle after the offending accept.

## Configuration
- FFT_BITREV_EN defined: sample k is written to slot bitrev_LOG2N(k). The output is then in bit-reversed order, ready for a decimation-in-time stage.
- FFT_BITREV_EN undefined: natural order, slot k.
- Handshake and timing are identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - the default WIDTH
  - the bank state enum (EMPTY/FILLING/FULL)
  - function bitrev(index, nbits)
- Sub-module fft_frame_bank covers one bank: N-entry complex storage, write port (wr_en, slot, data), parallel read bus and synchronous clear. It is instantiated twice.
- The top level holds the counter, bank state, pointers, handshake and error logic.

## Test plan
- Reset, then N=16 and WIDTH=16 with samples k -> xr=k, xi=-k and in_last at k=15. Required: out_valid the cycle after the last accept; yr_out slot k = k and yi_out slot k = -k (slot bitrev(k) holds k when FFT_BITREV_EN is defined).
- out_ready held 0 while three frames are offered. Required: the second frame fills bank 1; in_ready drops after its 16th sample; the third frame stalls; on a single out_ready pulse, frame 1 is released, frame 2 is presented the next cycle, and in_ready rises.
- in_last at k=5. Required: frame_err pulses once, no out_valid, and the following full frame is captured intact starting at slot 0.
- 16 samples with no in_last. Required: the frame is presented and frame_err pulses once.
- rst_n low for one cycle during sample 9 of a frame while another frame is presented. Required: out_valid = 0, all outputs 0, in_ready = 1 the next cycle, and the next frame is captured normally.
- Back-to-back streaming of 8 frames with out_ready = 1. Required: in_ready stays 1 throughout and 8 out_valid handshakes occur with matching data.

Source files
------------

// File: rtl/fft_frame_buffer_pkg.sv
// fft_pkg: shared types and helpers for the FFT frame buffer slice.
// Bank occupancy state, default sample width and an index bit-reversal helper.
package fft_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   // Reverse the low nbits of index; bits above nbits return as zero.
   function automatic logic [7:0] bitrev(input logic [7:0] index, input int unsigned nbits);
      logic [7:0] r;
      r = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         r[i] = index[nbits - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Stream-in / frame-out bus of the FFT frame buffer.
// slave is the buffer's view, master is the surrounding datapath's view.
interface fft_frame_buffer_if
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned N     = 16
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     xr_in;
   logic [WIDTH-1:0]     xi_in;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*WIDTH-1:0]   yr_out;
   logic [N*WIDTH-1:0]   yi_out;
   logic                 frame_err;

   modport slave (
      input  in_valid, xr_in, xi_in, in_last, out_ready,
      output in_ready, out_valid, yr_out, yi_out, frame_err
   );

   modport master (
      output in_valid, xr_in, xi_in, in_last, out_ready,
      input  in_ready, out_valid, yr_out, yi_out, frame_err
   );

endinterface

// File: rtl/fft_frame_buffer_bank.sv
// fft_frame_bank: one N-entry complex sample store with a single write port,
// a fully parallel read bus and a synchronous clear of all entries.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned N     = 16,
   parameter int unsigned LOG2N = $clog2(N)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               wr_en,
   input  logic [LOG2N-1:0]   slot,
   input  logic [WIDTH-1:0]   dr,
   input  logic [WIDTH-1:0]   di,
   output logic [N*WIDTH-1:0] yr,
   output logic [N*WIDTH-1:0] yi
);

   logic [N*WIDTH-1:0] yr_q;
   logic [N*WIDTH-1:0] yi_q;

   // Storage: clear wins over write; otherwise write one slot.
   always_ff @(posedge clk) begin
      if (clr) begin
         yr_q <= '0;
         yi_q <= '0;
      end else if (wr_en) begin
         yr_q[slot*WIDTH +: WIDTH] <= dr;
         yi_q[slot*WIDTH +: WIDTH] <= di;
      end
   end

   assign yr = yr_q;
   assign yi = yi_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: assembles N-sample complex frames from a sample stream
// into two ping-pong banks and presents each complete frame in parallel.
// Build option: FFT_BITREV_EN stores sample k at slot bitrev(k).
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned N     = 16,
   parameter int unsigned LOG2N = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   fft_frame_buffer_if.slave bus
);

   localparam logic [LOG2N-1:0] KMAX = LOG2N'(N - 1);

   bank_state_t        st_q [2];
   bank_state_t        st_d [2];
   logic               wr_q, wr_d;
   logic               rd_q, rd_d;
   logic [LOG2N-1:0]   k_q, k_d;
   logic               err_q, err_d;

   logic               acc;
   logic               rel;
   logic [LOG2N-1:0]   slot;
   logic [N*WIDTH-1:0] yr_b0, yi_b0, yr_b1, yi_b1;

   assign bus.in_ready  = rst_n && (st_q[wr_q] != FULL);
   assign bus.out_valid = (st_q[rd_q] == FULL);
   assign bus.frame_err = err_q;
   assign bus.yr_out    = rd_q ? yr_b1 : yr_b0;
   assign bus.yi_out    = rd_q ? yi_b1 : yi_b0;

   assign acc = bus.in_valid && bus.in_ready;
   assign rel = bus.out_valid && bus.out_ready;

`ifdef FFT_BITREV_EN
   assign slot = LOG2N'(bitrev(8'(k_q), LOG2N));
`else
   assign slot = k_q;
`endif

   // Control registers: bank states, pointers, sample counter, error pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q[0] <= EMPTY;
         st_q[1] <= EMPTY;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         k_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

   // Next state. An accept and a release never target the same bank: the
   // write bank is never FULL when accepting and the read bank is always
   // FULL when releasing, so both updates can be applied in one cycle.
   always_comb begin
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      wr_d    = wr_q;
      rd_d    = rd_q;
      k_d     = k_q;
      err_d   = 1'b0;

      if (rel) begin
         st_d[rd_q] = EMPTY;
         rd_d       = ~rd_q;
      end

      if (acc) begin
         if (k_q == KMAX) begin
            st_d[wr_q] = FULL;
            wr_d       = ~wr_q;
            k_d        = '0;
            err_d      = !bus.in_last;
         end else if (bus.in_last) begin
            st_d[wr_q] = EMPTY;
            k_d        = '0;
            err_d      = 1'b1;
         end else begin
            st_d[wr_q] = FILLING;
            k_d        = k_q + 1'b1;
         end
      end
   end

   fft_frame_bank #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) u_bank0 (
      .clk   (clk),
      .clr   (!rst_n),
      .wr_en (acc && !wr_q),
      .slot  (slot),
      .dr    (bus.xr_in),
      .di    (bus.xi_in),
      .yr    (yr_b0),
      .yi    (yi_b0)
   );

   fft_frame_bank #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) u_bank1 (
      .clk   (clk),
      .clr   (!rst_n),
      .wr_en (acc && wr_q),
      .slot  (slot),
      .dr    (bus.xr_in),
      .di    (bus.xi_in),
      .yr    (yr_b1),
      .yi    (yi_b1)
   );

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer (WIDTH=16, N=16). Reference model: a queue of
// completed frames (at most two outstanding) plus the partial frame in progress.
module tb_fft_frame_buffer;

   localparam int W  = 16;
   localparam int NN = 16;

   typedef logic [2*W-1:0] samp_t;          // {xr, xi}
   typedef samp_t frame_t [NN];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_frame_buffer_if #(.WIDTH(W), .N(NN)) bus ();

   fft_frame_buffer #(.WIDTH(W), .N(NN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int     checks = 0;
   int     errors = 0;
   int     releases = 0;
   bit     m_err = 1'b0;
   samp_t  partial[$];
   frame_t frames[$];

   function automatic int slot_of(input int k);
`ifdef FFT_BITREV_EN
      int r;
      r = 0;
      for (int b = 0; b < 4; b++) if ((k >> b) & 1) r = r | (1 << (3 - b));
      return r;
`else
      return k;
`endif
   endfunction

   task automatic chk(input string tag, input logic [NN*W-1:0] obs, input logic [NN*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [NN*W-1:0] er, ei;
      chk("in_ready", 256'(bus.in_ready), 256'(frames.size() < 2));
      chk("out_valid", 256'(bus.out_valid), 256'(frames.size() > 0));
      chk("frame_err", 256'(bus.frame_err), 256'(m_err));
      if (frames.size() > 0) begin
         er = '0;
         ei = '0;
         for (int k = 0; k < NN; k++) begin
            er[slot_of(k)*W +: W] = frames[0][k][2*W-1:W];
            ei[slot_of(k)*W +: W] = frames[0][k][W-1:0];
         end
         chk("yr_out", bus.yr_out, er);
         chk("yi_out", bus.yi_out, ei);
      end
   endtask

   // One clock: drive, check at negedge, then advance the model at posedge.
   task automatic tick(input bit v, input samp_t s, input bit last, input bit ordy, output bit acc);
      bit rel, err_n;
      bus.in_valid  = v;
      bus.xr_in     = s[2*W-1:W];
      bus.xi_in     = s[W-1:0];
      bus.in_last   = last;
      bus.out_ready = ordy;
      @(negedge clk);
      check_outputs();
      acc = v && (frames.size() < 2);
      rel = ordy && (frames.size() > 0);
      @(posedge clk);
      err_n = 1'b0;
      if (rel) begin
         void'(frames.pop_front());
         releases++;
      end
      if (acc) begin
         partial.push_back(s);
         if (partial.size() == NN) begin
            frame_t f;
            for (int k = 0; k < NN; k++) f[k] = partial[k];
            frames.push_back(f);
            partial.delete();
            err_n = !last;
         end else if (last) begin
            partial.delete();
            err_n = 1'b1;
         end
      end
      m_err = err_n;
      #1;
   endtask

   task automatic idle(input bit ordy);
      bit a;
      tick(1'b0, '0, 1'b0, ordy, a);
   endtask

   // Offer n samples; in_last on index last_idx (-1: never). ramp gives xr=k, xi=-k.
   task automatic send(input int n, input int last_idx, input bit ordy, input bit ramp);
      int    i, budget;
      bit    a;
      samp_t s;
      i = 0;
      budget = 4 * n + 20;
      s = ramp ? {16'(0), 16'(0)} : samp_t'($urandom);
      while (i < n && budget > 0) begin
         tick(1'b1, s, (i == last_idx), ordy, a);
         budget--;
         if (a) begin
            i++;
            s = ramp ? {16'(i), 16'(-i)} : samp_t'($urandom);
         end
      end
      chk("send_done", 256'(i), 256'(n));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready_in_reset", 256'(bus.in_ready), 256'(0));
      @(posedge clk);
      frames.delete();
      partial.delete();
      m_err = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
      chk("rst_yr_out", bus.yr_out, '0);
      chk("rst_yi_out", bus.yi_out, '0);
      chk("rst_frame_err", 256'(bus.frame_err), 256'(0));
      chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit a;
      int base;
      bus.in_valid = 1'b0;
      bus.xr_in = '0;
      bus.xi_in = '0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      do_reset();

      // Ramp frame, presented then released
      send(NN, NN - 1, 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // Two frames held, third stalls, single release
      send(NN, NN - 1, 1'b0, 1'b0);
      send(NN, NN - 1, 1'b0, 1'b0);
      repeat (3) tick(1'b1, samp_t'($urandom), 1'b0, 1'b0, a);
      tick(1'b1, samp_t'($urandom), 1'b0, 1'b1, a);
      send(NN, NN - 1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Early in_last: discard, then a clean frame
      send(6, 5, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      send(NN, NN - 1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Full frame without in_last
      send(NN, -1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // Reset mid-frame while another frame is presented
      send(NN, NN - 1, 1'b0, 1'b0);
      send(9, -1, 1'b0, 1'b0);
      do_reset();
      send(NN, NN - 1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Back-to-back streaming, downstream always ready
      base = releases;
      for (int f = 0; f < 8; f++) send(NN, NN - 1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      chk("stream_handshakes", 256'(releases - base), 256'(8));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
